// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Dividend and quotient share a shift register; start/busy/done handshake.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_count;
  logic [DIVIDEND_W-1:0] r_dq;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W:0]    r_rem;
  logic                  r_busy;
  logic                  r_done;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_dbz;

  logic [DIVISOR_W+1:0]  w_shift;
  logic [DIVISOR_W+1:0]  w_dvs_ext;
  logic                  w_ge;
  logic [DIVISOR_W:0]    w_rem_nx;
  logic [DIVIDEND_W-1:0] w_dq_nx;
  logic                  w_last;

  // Shift the next dividend MSB into the partial remainder and trial-subtract.
  assign w_shift   = {r_rem, r_dq[DIVIDEND_W-1]};
  assign w_dvs_ext = {2'b00, r_dvs};
  assign w_ge      = (w_shift >= w_dvs_ext);
  assign w_rem_nx  = w_ge ? (DIVISOR_W+1)'(w_shift - w_dvs_ext)
                          : w_shift[DIVISOR_W:0];
  assign w_dq_nx   = {r_dq[DIVIDEND_W-2:0], w_ge};
  assign w_last    = (r_count == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
          if (start) begin
            r_dq        <= dividend;
            r_dvs       <= divisor;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            if (divisor == '0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_quotient <= '1;
              r_dbz      <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_count <= CNT_W'(DIVIDEND_W);
            end
          end
        end
        S_RUN: begin
          r_rem   <= w_rem_nx;
          r_dq    <= w_dq_nx;
          r_count <= r_count - CNT_W'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_dq_nx;
            r_remainder <= w_rem_nx[DIVISOR_W-1:0];
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep bench for seq_restoring_divider.
// Inputs change #1 after posedge or at negedge; outputs sampled at negedge.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_restoring_divider #(
    .DIVIDEND_W(8),
    .DIVISOR_W (4)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bcyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    bcyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'(done), 32'd1);
  endtask

  logic [7:0] va [3] = '{8'd255, 8'd5, 8'd0};
  logic [3:0] vb [3] = '{4'd1, 4'd15, 4'd9};
  logic [7:0] vq [3] = '{8'd255, 8'd0, 8'd0};
  logic [3:0] vr [3] = '{4'd0, 4'd5, 4'd0};

  initial begin
    int c, bc, sawdone;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'd100, 4'd7);
    wait_done(c, bc);
    check("t1_cycles", c, 9);
    check("t1_busy", bc, 8);
    check("t1_q", 32'(quotient), 14);
    check("t1_r", 32'(remainder), 2);
    check("t1_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    check("t1_pulse", 32'(done), 0);
    check("t1_hold", 32'(quotient), 14);

    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i]);
      wait_done(c, bc);
      check("t2_q", 32'(quotient), 32'(vq[i]));
      check("t2_r", 32'(remainder), 32'(vr[i]));
      @(negedge clk);
    end

    issue(8'd200, 4'd0);
    wait_done(c, bc);
    check("t3_cycles", c, 1);
    check("t3_busy", bc, 0);
    check("t3_q", 32'(quotient), 255);
    check("t3_r", 32'(remainder), 0);
    check("t3_dbz", 32'(div_by_zero), 1);
    repeat (3) @(negedge clk);
    check("t3_dbz_hold", 32'(div_by_zero), 1);
    check("t3_q_hold", 32'(quotient), 255);
    issue(8'd200, 4'd8);
    check("t3_dbz_clr", 32'(div_by_zero), 0);
    check("t3_busy_on", 32'(busy), 1);
    wait_done(c, bc);
    check("t3b_q", 32'(quotient), 25);
    check("t3b_r", 32'(remainder), 0);
    check("t3b_dbz", 32'(div_by_zero), 0);
    @(negedge clk);

    start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0; bc = 0; sawdone = 0;
    for (int i = 0; i < 20 && sawdone == 0; i++) begin
      @(negedge clk);
      c++;
      if (c == 4) begin start = 1'b1; dividend = 8'd50; divisor = 4'd3; end
      if (c == 5) start = 1'b0;
      if (busy) bc++;
      if (done) sawdone = 1;
    end
    check("t4_seen", sawdone, 1);
    check("t4_cycles", c, 9);
    check("t4_busy", bc, 8);
    check("t4_q", 32'(quotient), 14);
    check("t4_r", 32'(remainder), 2);
    issue(8'd50, 4'd3);
    check("t4_b2b_busy", 32'(busy), 1);
    wait_done(c, bc);
    check("t4_b2b_cycles", c, 9);
    check("t4_b2b_q", 32'(quotient), 16);
    check("t4_b2b_r", 32'(remainder), 2);
    @(negedge clk);

    issue(8'd100, 4'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0);
    check("t5_q", 32'(quotient), 0);
    check("t5_r", 32'(remainder), 0);
    check("t5_dbz", 32'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawdone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) sawdone++;
    end
    check("t5_nodone", sawdone, 0);
    issue(8'd63, 4'd4);
    wait_done(c, bc);
    check("t5_q2", 32'(quotient), 15);
    check("t5_r2", 32'(remainder), 3);
    @(negedge clk);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(8'(a), 4'(b));
        wait_done(c, bc);
        if (b == 0) begin
          check("sw_dbz", 32'(div_by_zero), 1);
          check("sw_q0", 32'(quotient), 255);
        end else begin
          check("sw_inv", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
          check("sw_rlt", 32'(32'(remainder) < 32'(b)), 1);
        end
      end
    end

    for (int x = 1; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        issue(8'(x * y), 4'(y));
        wait_done(c, bc);
        check("rt_q", 32'(quotient), 32'(x));
        check("rt_r", 32'(remainder), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
